// File: rtl/sva_result_collector.sv
// Collects SVA checker outcome pulses over a start/stop window and emits one
// verdict record per window through a valid/ready report port.
module sva_result_collector #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TS_W     = 32,
  parameter int unsigned MAX_FAIL = 1
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             start,
  input  logic             stop,
  input  logic             attempt_i,
  input  logic             succ_i,
  input  logic             lazy_i,
  input  logic             fail_i,
  output logic             busy,
  output logic             fail_sticky,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [1:0]       rpt_verdict,
  output logic             rpt_incomplete,
  output logic [CNT_W-1:0] rpt_attempts,
  output logic [CNT_W-1:0] rpt_succ,
  output logic [CNT_W-1:0] rpt_lazy,
  output logic [CNT_W-1:0] rpt_fail,
  output logic [TS_W-1:0]  rpt_first_fail_ts
);

  typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [TS_W-1:0]  TsMax   = '1;
  localparam logic [CNT_W-1:0] MaxFail = CNT_W'(MAX_FAIL);

  localparam logic [1:0] VerdictPass = 2'b01;
  localparam logic [1:0] VerdictFail = 2'b10;
  localparam logic [1:0] VerdictVac  = 2'b11;

  state_e state_q, state_d;

  logic [CNT_W-1:0] att_q, att_d, succ_q, succ_d, lazy_q, lazy_d, fail_q, fail_d;
  logic [TS_W-1:0]  ts_q, ts_d, ff_q, ff_d;
  logic             sticky_q, sticky_d;
  logic             busy_q;

  logic             valid_q, valid_d;
  logic [1:0]       verdict_q, verdict_d;
  logic             inc_q, inc_d;
  logic [CNT_W-1:0] snap_att_q, snap_att_d, snap_succ_q, snap_succ_d;
  logic [CNT_W-1:0] snap_lazy_q, snap_lazy_d, snap_fail_q, snap_fail_d;
  logic [TS_W-1:0]  snap_ts_q, snap_ts_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CntMax)) ? v + CNT_W'(1) : v;
  endfunction

  // Tallies as they stand after this RUN cycle's events, so the stop cycle counts.
  logic [CNT_W-1:0] att_inc, succ_inc, lazy_inc, fail_inc;
  logic [TS_W-1:0]  ff_upd;
  logic [CNT_W+1:0] done_sum;
  logic             any_sat;
  logic             inc_calc;
  logic [1:0]       verdict_calc;

  assign att_inc  = sat_inc(att_q, attempt_i);
  assign succ_inc = sat_inc(succ_q, succ_i);
  assign lazy_inc = sat_inc(lazy_q, lazy_i);
  assign fail_inc = sat_inc(fail_q, fail_i);
  assign ff_upd   = (fail_i && !sticky_q) ? ts_q : ff_q;

  assign done_sum = {2'b00, succ_inc} + {2'b00, lazy_inc} + {2'b00, fail_inc};
  assign any_sat  = (att_inc == CntMax) || (succ_inc == CntMax) ||
                    (lazy_inc == CntMax) || (fail_inc == CntMax);
  // A saturated tally no longer tells us whether threads are still open.
  assign inc_calc = !any_sat && ({2'b00, att_inc} != done_sum);

  always_comb begin
    verdict_calc = VerdictVac;
    if (fail_inc >= MaxFail) begin
      verdict_calc = VerdictFail;
    end else if (succ_inc != '0) begin
      verdict_calc = VerdictPass;
    end
  end

  always_comb begin
    state_d     = state_q;
    att_d       = att_q;
    succ_d      = succ_q;
    lazy_d      = lazy_q;
    fail_d      = fail_q;
    ts_d        = ts_q;
    ff_d        = ff_q;
    sticky_d    = sticky_q;
    valid_d     = valid_q;
    verdict_d   = verdict_q;
    inc_d       = inc_q;
    snap_att_d  = snap_att_q;
    snap_succ_d = snap_succ_q;
    snap_lazy_d = snap_lazy_q;
    snap_fail_d = snap_fail_q;
    snap_ts_d   = snap_ts_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          att_d    = '0;
          succ_d   = '0;
          lazy_d   = '0;
          fail_d   = '0;
          ts_d     = '0;
          ff_d     = '1;
          sticky_d = 1'b0;
        end
      end
      StRun: begin
        att_d  = att_inc;
        succ_d = succ_inc;
        lazy_d = lazy_inc;
        fail_d = fail_inc;
        ts_d   = (ts_q == TsMax) ? ts_q : ts_q + TS_W'(1);
        ff_d   = ff_upd;
        if (fail_i) begin
          sticky_d = 1'b1;
        end
        if (stop) begin
          state_d     = StReport;
          valid_d     = 1'b1;
          verdict_d   = verdict_calc;
          inc_d       = inc_calc;
          snap_att_d  = att_inc;
          snap_succ_d = succ_inc;
          snap_lazy_d = lazy_inc;
          snap_fail_d = fail_inc;
          snap_ts_d   = ff_upd;
        end
      end
      StReport: begin
        if (rpt_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q     <= StIdle;
      att_q       <= '0;
      succ_q      <= '0;
      lazy_q      <= '0;
      fail_q      <= '0;
      ts_q        <= '0;
      ff_q        <= '1;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      verdict_q   <= 2'b00;
      inc_q       <= 1'b0;
      snap_att_q  <= '0;
      snap_succ_q <= '0;
      snap_lazy_q <= '0;
      snap_fail_q <= '0;
      snap_ts_q   <= '1;
    end else begin
      state_q     <= state_d;
      att_q       <= att_d;
      succ_q      <= succ_d;
      lazy_q      <= lazy_d;
      fail_q      <= fail_d;
      ts_q        <= ts_d;
      ff_q        <= ff_d;
      sticky_q    <= sticky_d;
      busy_q      <= (state_d == StRun);
      valid_q     <= valid_d;
      verdict_q   <= verdict_d;
      inc_q       <= inc_d;
      snap_att_q  <= snap_att_d;
      snap_succ_q <= snap_succ_d;
      snap_lazy_q <= snap_lazy_d;
      snap_fail_q <= snap_fail_d;
      snap_ts_q   <= snap_ts_d;
    end
  end

  assign busy              = busy_q;
  assign fail_sticky       = sticky_q;
  assign rpt_valid         = valid_q;
  assign rpt_verdict       = verdict_q;
  assign rpt_incomplete    = inc_q;
  assign rpt_attempts      = snap_att_q;
  assign rpt_succ          = snap_succ_q;
  assign rpt_lazy          = snap_lazy_q;
  assign rpt_fail          = snap_fail_q;
  assign rpt_first_fail_ts = snap_ts_q;

endmodule
